// File: rtl/uart_fifo_rx_controller.sv
// UART RX byte strobe to FIFO write port, with a small holding buffer.
// Define UART_FIFO_RX_DROP_CNT_EN to add the o_drop_count output.
module uart_fifo_rx_controller #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             i_rx_enable,
  input  logic             i_rx_dv,
  input  logic [WIDTH-1:0] i_rx_data,
  input  logic             i_full,
  input  logic             i_clr_ovf,
  output logic             o_w_en,
  output logic [WIDTH-1:0] o_w_data,
  output logic             o_pending,
`ifdef UART_FIFO_RX_DROP_CNT_EN
  output logic [15:0]      o_drop_count,
`endif
  output logic             o_overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    SETTLE
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count, count_nx;
  logic             push_req, push, pop, drop;
  logic             w_en_nx;

  assign push_req = i_rx_dv && i_rx_enable;
  assign pop      = (state == WRITE);
  // A full buffer still accepts a byte when the head leaves this cycle.
  assign push     = push_req && ((count != FULL_CNT) || pop);
  assign drop     = push_req && !push;

  always_comb begin
    count_nx = count;
    if (push && !pop)
      count_nx = count + CW'(1);
    else if (pop && !push)
      count_nx = count - CW'(1);
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if ((count != '0) && !i_full) state_nx = WRITE;
      WRITE:   state_nx = SETTLE;
      SETTLE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    w_en_nx = (state_nx == WRITE);
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!i_reset && push)
      mem[wr_ptr] <= i_rx_data;
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      o_w_en    <= 1'b0;
      o_w_data  <= '0;
      o_pending <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count     <= count_nx;
      o_w_en    <= w_en_nx;
      o_pending <= (count_nx != '0);
      if (w_en_nx)
        o_w_data <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset)
      o_overflow <= 1'b0;
    else if (drop)
      o_overflow <= 1'b1;
    else if (i_clr_ovf)
      o_overflow <= 1'b0;
  end

`ifdef UART_FIFO_RX_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (i_reset)
      o_drop_count <= '0;
    else if (drop && i_clr_ovf)
      o_drop_count <= 16'd1;
    else if (i_clr_ovf)
      o_drop_count <= '0;
    else if (drop && (o_drop_count != 16'hFFFF))
      o_drop_count <= o_drop_count + 16'd1;
  end
`endif

endmodule
